// File: rtl/sram_controller_if.sv
// Pipeline-side request/response bundle for the SRAM controller.
// The pipeline drives the master modport; the controller implements the slave modport.
interface sram_controller_if;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   logic        addr_err;

   modport master (
      output wr_en, rd_en, address, write_data,
      input  read_data, ready, addr_err
   );

   modport slave (
      input  wr_en, rd_en, address, write_data,
      output read_data, ready, addr_err
   );
endinterface

// File: rtl/sram_controller.sv
// Splits 32-bit data-memory accesses into two timed 16-bit async SRAM accesses.
// Optional range check is enabled by defining SRAM_BOUNDS_CHECK_EN.
module sram_controller #(
   parameter int WAIT_CYCLES = 3,
   parameter int BASE_ADDR   = 1024,
   parameter int SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   sram_controller_if.slave   bus,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_dq_oe,
   output logic               sram_we_n,
   output logic               sram_oe_n
);

   localparam int          CW   = $clog2(WAIT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
   localparam logic [31:0] BASE = 32'(BASE_ADDR);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic               is_wr;
   logic [SRAM_AW-2:0] idx;
   logic [31:0]        data;
   logic [15:0]        lo_buf;
   logic [31:0]        read_data_q;

   logic [31:0]        offset;
   logic [SRAM_AW-2:0] req_idx;
   logic               req;

   assign offset  = bus.address - BASE;
   assign req_idx = offset[SRAM_AW:2];
   assign req     = bus.wr_en | bus.rd_en;

   // Only ready looks at the live request; every SRAM pin comes from a flop.
   assign bus.ready     = (state == IDLE) ? !req : (state == DONE);
   assign bus.read_data = read_data_q;

`ifdef SRAM_BOUNDS_CHECK_EN
   logic addr_err_q;
   logic out_of_range;
   assign out_of_range = (bus.address < BASE) || (offset[31:SRAM_AW+1] != '0);
   assign bus.addr_err = addr_err_q;
`else
   assign bus.addr_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         is_wr       <= 1'b0;
         idx         <= '0;
         data        <= '0;
         lo_buf      <= '0;
         read_data_q <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
`ifdef SRAM_BOUNDS_CHECK_EN
         addr_err_q  <= 1'b0;
`endif
      end else begin
`ifdef SRAM_BOUNDS_CHECK_EN
         addr_err_q <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (req) begin
                  is_wr <= bus.wr_en;
                  idx   <= req_idx;
                  data  <= bus.write_data;
                  cnt   <= '0;
`ifdef SRAM_BOUNDS_CHECK_EN
                  if (out_of_range) begin
                     state      <= DONE;
                     addr_err_q <= 1'b1;
                  end else
`endif
                  begin
                     // NOTE: strobes are set up one edge early so they are clean flop outputs in LO.
                     state       <= LO;
                     sram_addr   <= {req_idx, 1'b0};
                     sram_dq_out <= bus.write_data[15:0];
                     sram_dq_oe  <= bus.wr_en;
                     sram_we_n   <= !bus.wr_en;
                     sram_oe_n   <= bus.wr_en;
                  end
               end
            end
            LO: begin
               if (cnt == LAST) begin
                  cnt         <= '0;
                  state       <= HI;
                  sram_addr   <= {idx, 1'b1};
                  sram_dq_out <= data[31:16];
                  if (!is_wr) lo_buf <= sram_dq_in;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HI: begin
               if (cnt == LAST) begin
                  cnt        <= '0;
                  state      <= DONE;
                  sram_dq_oe <= 1'b0;
                  sram_we_n  <= 1'b1;
                  sram_oe_n  <= 1'b1;
                  if (!is_wr) read_data_q <= {sram_dq_in, lo_buf};
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Memory-stage responder for the pipeline's data-memory requests (mem_r_en/mem_w_en, address, store value).
- Drives an external 16-bit asynchronous SRAM. Each 32-bit word access is split into two 16-bit half accesses with a programmable number of wait cycles.
- Deasserts ready while busy; upstream uses !ready as the pipeline freeze for every stage register.

Parameters:
- WAIT_CYCLES, 3, cycles each half access is held on the SRAM pins (must be >= 1).
- BASE_ADDR, 1024, CPU byte address that maps to SRAM word 0.
- SRAM_AW, 18, SRAM half-word address width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- wr_en  input  1  store request from the memory stage.
- rd_en  input  1  load request from the memory stage.
- address  input  32  CPU byte address, word aligned.
- write_data  input  32  store value.
- read_data  output  32  load result; valid while ready=1 after a read.
- ready  output  1  0 = busy, freeze the pipeline.
- addr_err  output  1  one-cycle pulse on an out-of-window access (optional feature).
- sram_addr  output  SRAM_AW  SRAM half-word address.
- sram_dq_out  output  16  SRAM write data.
- sram_dq_in  input  16  SRAM read data.
- sram_dq_oe  output  1  1 = drive sram_dq_out onto the bus.
- sram_we_n  output  1  SRAM write strobe, active low.
- sram_oe_n  output  1  SRAM output enable, active low.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset forces:
  - state IDLE, counter 0;
  - read_data 0, addr_err 0, sram_addr 0, sram_dq_out 0;
  - sram_dq_oe 0, sram_we_n 1, sram_oe_n 1.
  - ready = 1 after reset.
  - Reset mid-operation aborts immediately. Strobes go inactive in the same cycle and no partial read_data update occurs.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - ready = !(wr_en | rd_en), combinational.
  - On a request, latch at the edge: op (wr_en has priority if both are set), word index = (address - BASE_ADDR) >> 2, and write_data. Go to LO with counter 0.
- LO:
  - sram_addr = {word index, 1'b0}.
  - Write: sram_dq_out = data[15:0], sram_dq_oe = 1, sram_we_n = 0.
  - Read: sram_oe_n = 0, sram_dq_oe = 0.
  - Counter increments each cycle. On the cycle where counter == WAIT_CYCLES-1:
    - read: sample sram_dq_in into lo_buf;
    - clear the counter and go to HI.
- HI:
  - Same as LO, but sram_addr = {word index, 1'b1} and the data is data[31:16].
  - On the final cycle, a read updates read_data <= {sram_dq_in, lo_buf}. Go to DONE.
- DONE:
  - ready = 1 and all strobes are inactive. Unconditionally go to IDLE on the next edge.
  - The pipeline advances on this edge; a new request presented in the following cycle starts a fresh access.
- Latency: request first seen in IDLE at cycle 0 -> ready = 1 in cycle 2*WAIT_CYCLES+1 (cycle 7 at the default).
- Requests deasserted mid-access are ignored; an access in flight always completes.
- read_data holds its value across writes and until the next read completes.
- Strobes are decoded from registered state/counter/op only. No strobe glitches on input changes.
- Word index is truncated to SRAM_AW-1 bits. Address bits [1:0] are ignored.

Optional Feature:
- Macro SRAM_BOUNDS_CHECK_EN.
- Defined:
  - In IDLE, a request with address < BASE_ADDR, or a word index >= 2^(SRAM_AW-1), goes directly to DONE.
  - No SRAM strobes are asserted and read_data is unchanged.
  - addr_err pulses 1 for the DONE cycle; ready = 1 in cycle 1.
- Undefined: no range check; addr_err is tied 0 and the address is wrapped by truncation.

Test Plan:
- Write, WAIT_CYCLES=3: wr_en=1, address=1028, write_data=0xDEADBEEF -> sram_addr=2 with dq_out=0xBEEF and we_n=0 for 3 cycles, then sram_addr=3 with dq_out=0xDEAD for 3 cycles; ready=1 in cycle 7.
- Read back: SRAM model holds [2]=0xBEEF, [3]=0xDEAD; rd_en at address=1028 -> oe_n=0 for 6 cycles, we_n stays 1; read_data=0xDEADBEEF with ready=1 in cycle 7.
- Back-to-back: write 0x12345678 at 1024, then read 1024 immediately after DONE -> the second access starts the cycle after DONE; read_data=0x12345678.
- Simultaneous rd_en=wr_en=1 -> a write is performed (we_n pulses low); read_data is unchanged.
- Reset asserted in cycle 4 of a write -> we_n=1, sram_dq_oe=0 and ready=1 immediately; the next request starts from LO.
- With SRAM_BOUNDS_CHECK_EN, rd_en at address=512 -> no strobes, addr_err=1 and ready=1 in cycle 1; read_data is unchanged.
